// File: rtl/btn_debounce.sv
// Push-button conditioner: synchroniser, bounce filter, press/release/long strobes.
// Optional long-press detector is built only when BTN_LONG_PRESS_EN is defined.
module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int CNT_W           = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_db,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REL_CHK
    } state_t;

    localparam longint CNT_SPAN = longint'(1) << CNT_W;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("btn_debounce: SYNC_STAGES must be >= 2");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
            $error("btn_debounce: DEBOUNCE_CYCLES must be >= 1");
        end
        if (LONG_CYCLES < 1) begin : g_bad_long
            $error("btn_debounce: LONG_CYCLES must be >= 1");
        end
        if (longint'(DEBOUNCE_CYCLES) > CNT_SPAN) begin : g_bad_db_w
            $error("btn_debounce: CNT_W too narrow for DEBOUNCE_CYCLES");
        end
        if (longint'(LONG_CYCLES) > CNT_SPAN) begin : g_bad_long_w
            $error("btn_debounce: CNT_W too narrow for LONG_CYCLES");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync;
    logic                   bs;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   press_ok;
    logic                   release_ok;

    // Shift the raw button through the synchroniser; reset looks released.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign bs = sync[SYNC_STAGES-1];

    // A level is accepted once it has been seen for the full window.
    assign press_ok   = (state == PRESS_CHK) && !bs && (cnt == DB_LAST);
    assign release_ok = (state == REL_CHK) && bs && (cnt == DB_LAST);

    // Debounce FSM with registered level and edge strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_db        <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bs) begin
                        state <= PRESS_CHK;
                        cnt   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (bs) begin
                        state <= IDLE;
                    end else if (press_ok) begin
                        state       <= HELD;
                        btn_db      <= 1'b0;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (bs) begin
                        state <= REL_CHK;
                        cnt   <= '0;
                    end
                end
                REL_CHK: begin
                    if (!bs) begin
                        state <= HELD;
                    end else if (release_ok) begin
                        state         <= IDLE;
                        btn_db        <= 1'b1;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    logic [CNT_W-1:0] hold_cnt;
    logic             long_done;

    // Time the accepted press; fire once when the hold reaches the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt   <= '0;
            long_done  <= 1'b0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (press_ok || release_ok) begin
                hold_cnt  <= '0;
                long_done <= 1'b0;
            end else if (state == HELD || state == REL_CHK) begin
                if (hold_cnt != LONG_LAST) begin
                    hold_cnt <= hold_cnt + CNT_W'(1);
                end else if (!long_done) begin
                    long_press <= 1'b1;
                    long_done  <= 1'b1;
                end
            end
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule
